// File: rtl/io_rx_port.sv
// -----------------------------------------------------------------------------
// io_rx_port
//   Serial input port for the CPU bus. Receives 8N1 UART frames on rx and
//   queues the received bytes in a small FIFO. The head byte and a status byte
//   are presented combinationally to the bus mux.
//
// Ports
//   clk_out     in   1  gated CPU clock; all state changes on the rising edge
//   rst         in   1  asynchronous, active-high reset
//   rx          in   1  serial line, idle high, asynchronous to clk_out
//   rd_en       in   1  pop the head byte at this edge
//   stat_clr    in   1  clear the sticky overrun/frame_err flags at this edge
//   data_out    out  8  FIFO head byte, 8'h00 when the FIFO is empty
//   status_out  out  8  {4'b0, overrun, frame_err, full, not_empty}
//   not_empty   out  1  FIFO holds at least one byte
//   full        out  1  FIFO holds FIFO_DEPTH bytes
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module io_rx_port #(
    parameter int CLKS_PER_BIT = 16,   // even, >= 4
    parameter int FIFO_DEPTH   = 4     // power of 2, >= 2
) (
    input  logic       clk_out,
    input  logic       rst,
    input  logic       rx,
    input  logic       rd_en,
    input  logic       stat_clr,
    output logic [7:0] data_out,
    output logic [7:0] status_out,
    output logic       not_empty,
    output logic       full
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);

    localparam logic [CNT_W-1:0] BAUD_MID  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [PTR_W:0]   DEPTH_C   = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BRK      // line held low after a bad stop bit; wait for it to go high
    } state_t;

    state_t           state, next_state;
    logic             rx_meta, rxs;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_cnt;
    logic [7:0]       shift;

    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   count;
    logic             overrun, frame_err;

    logic mid_start, bit_end;
    logic sample_bit, push, frame_set, cnt_clr, cnt_run;
    logic do_push, do_pop, overrun_set;

    // Two-flop synchronizer; resets to the idle-high line level so a reset
    // never looks like a start bit.
    // NOTE: every clocked process uses non-blocking assignments so all flops
    // see pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk_out or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
        end
    end

    assign mid_start = (baud_cnt == BAUD_MID);
    assign bit_end   = (baud_cnt == BAUD_LAST);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk_out or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // ---------------- FSM: next-state logic ----------------
    // NOTE: combinational blocks assign a default first so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:  if (!rxs) next_state = START;
            START: if (mid_start) next_state = rxs ? IDLE : DATA;
            DATA:  if (bit_end && bit_cnt == 3'd7) next_state = STOP;
            STOP:  if (bit_end) next_state = rxs ? IDLE : BRK;
            BRK:   if (rxs) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // ---------------- FSM: output decode ----------------
    always_comb begin
        sample_bit = (state == DATA) && bit_end;
        push       = (state == STOP) && bit_end && rxs;
        frame_set  = (state == STOP) && bit_end && !rxs;
        cnt_run    = (state == START) || (state == DATA) || (state == STOP);
        // Every state change starts the next phase from a zero baud count;
        // bit_end also restarts it between data bits.
        cnt_clr    = (next_state != state) || bit_end;
    end

    // ---------------- Receive datapath ----------------
    always_ff @(posedge clk_out or posedge rst) begin
        if (rst) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
        end else begin
            if (!cnt_run || cnt_clr) baud_cnt <= '0;
            else                     baud_cnt <= baud_cnt + 1'b1;

            if (state != DATA) bit_cnt <= '0;
            else if (bit_end)  bit_cnt <= bit_cnt + 1'b1;

            // LSB arrives first, so shift in from the top.
            if (sample_bit) shift <= {rxs, shift[7:1]};
        end
    end

    // ---------------- FIFO ----------------
    assign not_empty = (count != '0);
    assign full      = (count == DEPTH_C);

    // A pop on an empty FIFO is ignored; a push into a full FIFO only
    // succeeds when a pop frees the head slot on the same edge.
    assign do_pop      = rd_en && not_empty;
    assign do_push     = push && (!full || do_pop);
    assign overrun_set = push && full && !do_pop;

    always_ff @(posedge clk_out or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; the pointers and count define
    // which entries are valid, and data_out is forced to zero when empty.
    always_ff @(posedge clk_out) begin
        if (do_push) mem[wr_ptr] <= shift;
    end

    // Sticky flags: a new error on the same edge as stat_clr wins.
    always_ff @(posedge clk_out or posedge rst) begin
        if (rst) begin
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            overrun   <= overrun_set | (overrun   & ~stat_clr);
            frame_err <= frame_set   | (frame_err & ~stat_clr);
        end
    end

    assign data_out   = not_empty ? mem[rd_ptr] : 8'h00;
    assign status_out = {4'b0000, overrun, frame_err, full, not_empty};

endmodule
